// File: rtl/fb_fill_engine_if.sv
// Framebuffer write port between the fill engine and the unified memory write arbiter.
// The engine drives the request; the arbiter answers with fb_ready.
interface fb_fill_engine_if;
    logic        fb_we;
    logic [31:0] fb_adr;
    logic [31:0] fb_wdata;
    logic        fb_ready;

    modport master (output fb_we, fb_adr, fb_wdata, input fb_ready);
    modport slave  (input fb_we, fb_adr, fb_wdata, output fb_ready);
endinterface

// File: rtl/fb_fill_engine.sv
// Rectangle fill engine: the CPU programs a box and a colour, and the engine writes that
// colour into every covered pixel word of video memory, clipped to the screen.
module fb_fill_engine #(
    parameter logic [31:0] FB_BASE   = 32'h0000_2000,
    parameter int          FB_WIDTH  = 160,
    parameter int          FB_HEIGHT = 120,
    parameter int          CW        = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_addr,
    input  logic [31:0]       cfg_wdata,
    output logic              busy,
    output logic              done,
    fb_fill_engine_if.master  fb
);
    typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

    localparam logic [CW:0]  XMAX     = (CW+1)'(FB_WIDTH);
    localparam logic [CW:0]  YMAX     = (CW+1)'(FB_HEIGHT);
    localparam logic [31:0]  ROW_STEP = 32'(4 * FB_WIDTH);

    state_t        state, state_nxt;
    logic [CW-1:0] x0, y0, w, h, cx, cy;
    logic [11:0]   color;
    logic [CW:0]   xe, ye, xsum, ysum, cx_inc, cy_inc;
    logic [31:0]   rowbase;
    logic          empty, row_end, last;
    logic          cfg_unused;

    assign cfg_unused = ^cfg_wdata[31:CW];

    // Clip edges are one bit wider than the fields so X0+W never wraps.
    assign xsum   = {1'b0, x0} + {1'b0, w};
    assign ysum   = {1'b0, y0} + {1'b0, h};
    assign empty  = (w == '0) || (h == '0) || ({1'b0, x0} >= XMAX) || ({1'b0, y0} >= YMAX);
    assign cx_inc = {1'b0, cx} + (CW+1)'(1);
    assign cy_inc = {1'b0, cy} + (CW+1)'(1);
    assign row_end = !(cx_inc < xe);
    assign last    = row_end && !(cy_inc < ye);

    always_comb begin
        state_nxt   = state;
        busy        = 1'b0;
        done        = 1'b0;
        fb.fb_we    = 1'b0;
        fb.fb_adr   = '0;
        fb.fb_wdata = '0;
        case (state)
            IDLE:  if (cfg_we && cfg_addr == 3'd5 && cfg_wdata[0]) state_nxt = SETUP;
            SETUP: begin
                busy      = 1'b1;
                state_nxt = empty ? DONE : FILL;
            end
            FILL: begin
                busy        = 1'b1;
                fb.fb_we    = 1'b1;
                fb.fb_adr   = rowbase + (32'(cx) << 2);
                fb.fb_wdata = {20'b0, color};
                if (fb.fb_ready && last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            x0      <= '0;
            y0      <= '0;
            w       <= '0;
            h       <= '0;
            color   <= '0;
            cx      <= '0;
            cy      <= '0;
            xe      <= '0;
            ye      <= '0;
            rowbase <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (cfg_we) begin
                    case (cfg_addr)
                        3'd0:    x0    <= cfg_wdata[CW-1:0];
                        3'd1:    y0    <= cfg_wdata[CW-1:0];
                        3'd2:    w     <= cfg_wdata[CW-1:0];
                        3'd3:    h     <= cfg_wdata[CW-1:0];
                        3'd4:    color <= cfg_wdata[11:0];
                        default: ;
                    endcase
                end
                SETUP: begin
                    xe      <= (xsum > XMAX) ? XMAX : xsum;
                    ye      <= (ysum > YMAX) ? YMAX : ysum;
                    cx      <= x0;
                    cy      <= y0;
                    rowbase <= FB_BASE + ((32'(y0) * 32'(FB_WIDTH)) << 2);
                end
                FILL: if (fb.fb_ready) begin
                    if (!row_end) begin
                        cx <= cx_inc[CW-1:0];
                    end else if (!last) begin
                        cx      <= x0;
                        cy      <= cy_inc[CW-1:0];
                        rowbase <= rowbase + ROW_STEP;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fb_fill_engine.sv
// Bench for fb_fill_engine: table of fills with hand-derived counts/addresses, random fills
// checked against a pixel-list model, plus busy-write, start-in-DONE and mid-fill reset sequences.
module tb_fb_fill_engine;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = 3'd0;
    logic [31:0] cfg_wdata = 32'd0;
    logic        busy, done;

    fb_fill_engine_if bus();

    fb_fill_engine dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .busy      (busy),
        .done      (done),
        .fb        (bus)
    );

    always #20 clk = ~clk;

    typedef struct {
        int          x, y, w, h;
        logic [31:0] col;
        int          mode;      // 0: ready always, 1: ready 1,0,0,..., 2: random ready
        int          exp_n;
        logic [31:0] exp_first;
    } vec_t;

    vec_t        vecs[8];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    // Reference: the list of covered on-screen pixels, row-major, as byte addresses.
    task automatic model(input int x, input int y, input int w, input int h);
        int xm, ym, wm, hm;
        xm = x & 511; ym = y & 511; wm = w & 511; hm = h & 511;
        exp_q.delete();
        for (int yy = ym; yy < ym + hm && yy < 120; yy++)
            for (int xx = xm; xx < xm + wm && xx < 160; xx++)
                exp_q.push_back(32'h2000 + 32'(4 * (yy * 160 + xx)));
    endtask

    task automatic cfg(input logic [2:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // inj 1: register writes and a restart while filling; inj 2: start during the DONE cycle.
    task automatic run_fill(input string nm, input bit prog, input int x, input int y,
                            input int w, input int h, input logic [31:0] col, input int mode,
                            input int inj, output int nwr, output logic [31:0] first);
        int cyc, done_cyc, busy_cnt, done_cnt, post_bad, bad_stall, bad_data, bad_ord;
        logic rdy, stall;
        logic [31:0] padr, pdat;
        if (prog) begin
            cfg(3'd0, x); cfg(3'd1, y); cfg(3'd2, w); cfg(3'd3, h); cfg(3'd4, col);
        end
        model(x, y, w, h);
        got_q.delete();
        cfg(3'd5, 32'd1);
        cyc = 0; done_cyc = 0; busy_cnt = 0; done_cnt = 0; post_bad = 0;
        bad_stall = 0; bad_data = 0; bad_ord = 0; stall = 1'b0; padr = '0; pdat = '0;
        while (cyc < 2000 && !(done_cyc != 0 && cyc >= done_cyc + 3)) begin
            cyc++;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc - 1) % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.fb_ready = rdy;
            if (inj == 1) begin
                cfg_we    = (cyc >= 3 && cyc <= 5);
                cfg_addr  = (cyc == 3) ? 3'd0 : (cyc == 4) ? 3'd4 : 3'd5;
                cfg_wdata = (cyc == 3) ? 32'd50 : (cyc == 4) ? 32'hABC : 32'd1;
            end
            if (inj == 2) begin
                cfg_we = (done === 1'b1); cfg_addr = 3'd5; cfg_wdata = 32'd1;
            end
            if (stall && (bus.fb_we !== 1'b1 || bus.fb_adr !== padr || bus.fb_wdata !== pdat))
                bad_stall++;
            stall = 1'b0;
            if (bus.fb_we === 1'b1) begin
                if (bus.fb_wdata !== {20'b0, col[11:0]}) bad_data++;
                if (rdy) got_q.push_back(bus.fb_adr);
                else begin
                    stall = 1'b1; padr = bus.fb_adr; pdat = bus.fb_wdata;
                end
            end
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (done_cyc != 0 && cyc > done_cyc && (busy !== 1'b0 || bus.fb_we !== 1'b0))
                post_bad++;
            @(negedge clk);
        end
        cfg_we = 1'b0;
        bus.fb_ready = 1'b1;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) bad_ord++;
        chk({nm, " done_seen"}, 32'(done_cyc != 0), 32'd1);
        chk({nm, " writes"}, 32'(got_q.size()), 32'(exp_q.size()));
        chk({nm, " order"}, 32'(bad_ord), 32'd0);
        chk({nm, " done_pulses"}, 32'(done_cnt), 32'd1);
        chk({nm, " busy_cycles"}, 32'(busy_cnt), 32'(done_cyc - 1));
        if (mode == 0) chk({nm, " latency"}, 32'(done_cyc), 32'(exp_q.size() + 2));
        chk({nm, " stall_hold"}, 32'(bad_stall), 32'd0);
        chk({nm, " wdata"}, 32'(bad_data), 32'd0);
        chk({nm, " idle_after"}, 32'(post_bad), 32'd0);
        nwr = got_q.size();
        first = (got_q.size() > 0) ? got_q[0] : 32'd0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int nwr, wcnt, cyc;
        logic [31:0] first;
        vecs[0] = '{2, 3, 3, 2, 32'h0000_0F00, 0, 6, 32'h0000_2788};
        vecs[1] = '{2, 3, 3, 2, 32'h0000_0F00, 1, 6, 32'h0000_2788};
        vecs[2] = '{158, 119, 10, 10, 32'h0FFF_F0A5, 0, 2, 32'h0001_4BF8};
        vecs[3] = '{5, 5, 0, 4, 32'h0000_0001, 0, 0, 32'h0};
        vecs[4] = '{200, 10, 5, 5, 32'h0000_0002, 0, 0, 32'h0};
        vecs[5] = '{0, 0, 1, 1, 32'h0000_0ABC, 1, 1, 32'h0000_2000};
        vecs[6] = '{0, 118, 2, 5, 32'h0000_0123, 2, 4, 32'h0001_4700};
        vecs[7] = '{10, 20, 4, 0, 32'h0000_0777, 0, 0, 32'h0};
        bus.fb_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset fb_we", 32'(bus.fb_we), 32'd0);
        chk("reset fb_adr", bus.fb_adr, 32'd0);
        chk("reset fb_wdata", bus.fb_wdata, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_fill($sformatf("vec%0d", i), 1'b1, vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h,
                     vecs[i].col, vecs[i].mode, 0, nwr, first);
            chk($sformatf("vec%0d count", i), 32'(nwr), 32'(vecs[i].exp_n));
            chk($sformatf("vec%0d first_adr", i), first, vecs[i].exp_first);
        end

        for (int i = 0; i < 8; i++)
            run_fill($sformatf("rnd%0d", i), 1'b1, int'($urandom_range(0, 170)),
                     int'($urandom_range(0, 125)), int'($urandom_range(0, 20)),
                     int'($urandom_range(0, 8)), $urandom, int'($urandom_range(0, 2)), 0,
                     nwr, first);

        run_fill("busy_writes", 1'b1, 2, 3, 3, 2, 32'h0000_0F00, 0, 1, nwr, first);
        chk("busy_writes first_adr", first, 32'h0000_2788);
        run_fill("start_in_done", 1'b1, 4, 4, 2, 2, 32'h0000_0055, 0, 2, nwr, first);

        // Reset in the middle of a fill, after three accepted writes.
        cfg(3'd0, 32'd2); cfg(3'd1, 32'd3); cfg(3'd2, 32'd3); cfg(3'd3, 32'd2);
        cfg(3'd4, 32'hF00);
        cfg(3'd5, 32'd1);
        bus.fb_ready = 1'b1;
        wcnt = 0; cyc = 0;
        while (wcnt < 3 && cyc < 50) begin
            cyc++;
            if (bus.fb_we === 1'b1) wcnt++;
            @(negedge clk);
        end
        chk("midrst writes_before", 32'(wcnt), 32'd3);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst fb_we", 32'(bus.fb_we), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst fb_adr", bus.fb_adr, 32'd0);
        reset = 1'b1;
        wcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.fb_we !== 1'b0 || busy !== 1'b0) wcnt++;
        end
        chk("midrst quiet_after", 32'(wcnt), 32'd0);
        // Cleared registers mean a bare start is an empty fill.
        run_fill("midrst restart", 1'b0, 0, 0, 0, 0, 32'd0, 0, 0, nwr, first);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
